instruction_memory_loader: RTL and testbench

Parametrised, synchronous-read instruction memory for the pipeline's IF stage. It replaces a hard-wired program image with a RAM that clears itself to NOPs after reset and is then filled word by word through a valid/ready load port. Fetch is refused until loading completes. The block sits between the PC register and the IF/ID register and supports stalls, fault reporting and in-field reload.

---
 rtl/imem_pkg.sv | 14 +
 rtl/imem_ram.sv | 35 +++
 rtl/instruction_memory_loader.sv | 182 ++++++++++++++++++
 tb/tb_instruction_memory_loader.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory loader.
// Holds the loader FSM state encoding and the default NOP fill word.
// Imported by the RAM and the top level.
package imem_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } imem_state_e;

  localparam logic [31:0] IMEM_NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/imem_ram.sv
// Single-clock simple dual-port RAM: one write port, one registered read port.
// Latency: read data appears one cycle after re_i; it holds while re_i is low.
// Backpressure: none; the caller gates writes and reads. No reset on storage.
module imem_ram
  import imem_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] waddr_i,
  input  logic [WIDTH-1:0]     wdata_i,
  input  logic                 re_i,
  input  logic [ADDR_BITS-1:0] raddr_i,
  output logic [WIDTH-1:0]     rdata_o
);

  logic [WIDTH-1:0] mem_q [2**ADDR_BITS];
  logic [WIDTH-1:0] rdata_q;

  // Write port and read-enabled output register; holding rdata_q is what
  // lets the top keep the fetched word stable through stalls.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instruction_memory_loader.sv
// IF-stage instruction RAM: self-clears to NOP, loads via valid/ready, then serves fetches.
// Latency: 1 cycle from fetch request to registered Instruction; CLEAR takes 2**ADDR_BITS cycles.
// Backpressure: LoadReady only in LOAD; Stall freezes the fetch outputs. IMEM_PARITY_EN adds parity.
module instruction_memory_loader
  import imem_pkg::*;
#(
  parameter int                    ADDR_BITS  = 8,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = DATA_WIDTH'(IMEM_NOP_WORD)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  FetchReq,
  input  logic [31:0]           Address,
  input  logic                  Stall,
  output logic [DATA_WIDTH-1:0] Instruction,
  output logic                  InstrValid,
  output logic                  AddrFault,
  input  logic                  LoadValid,
  input  logic [DATA_WIDTH-1:0] LoadData,
  input  logic                  LoadLast,
  output logic                  LoadReady,
  output logic                  LoadDone,
  input  logic                  Reload
);

`ifdef IMEM_PARITY_EN
  localparam int RAM_W = DATA_WIDTH + 1;
`else
  localparam int RAM_W = DATA_WIDTH;
`endif
  localparam logic [ADDR_BITS-1:0] LAST_IDX = '1;

  imem_state_e state_q, state_d;
  logic [ADDR_BITS-1:0] ptr_q, ptr_d;

  logic                  ram_we;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [RAM_W-1:0]      ram_wdata;
  logic                  ram_re;
  logic [RAM_W-1:0]      ram_rdata;
  logic [DATA_WIDTH-1:0] ram_word;
  logic                  par_err;

  logic                  fetch_en;
  logic                  addr_fault;
  logic [ADDR_BITS-1:0]  fetch_idx;

  // Output hold state: use_ram_q selects the RAM read register as the
  // instruction source, otherwise the output is the NOP fill word.
  logic valid_q, valid_d;
  logic fault_q, fault_d;
  logic use_ram_q, use_ram_d;

  // FSM state and clear/load pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state, pointer advance, RAM write port and load handshake.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ram_we    = 1'b0;
    wr_word   = NOP_WORD;
    LoadReady = 1'b0;
    LoadDone  = 1'b0;
    unique case (state_q)
      CLEAR: begin
        ram_we = 1'b1;
        if (ptr_q == LAST_IDX) begin
          state_d = LOAD;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_BITS'(1);
        end
      end
      LOAD: begin
        LoadReady = 1'b1;
        if (LoadValid) begin
          ram_we  = 1'b1;
          wr_word = LoadData;
          // The last slot ends loading even without LoadLast so the pointer never wraps.
          if (LoadLast || ptr_q == LAST_IDX) begin
            state_d = RUN;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + ADDR_BITS'(1);
          end
        end
      end
      RUN: begin
        LoadDone = 1'b1;
        if (Reload) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  assign fetch_en   = FetchReq & ~Stall;
  assign fetch_idx  = Address[ADDR_BITS+1:2];
  assign addr_fault = (Address[1:0] != 2'b00) || ((Address >> (ADDR_BITS + 2)) != 32'd0);
  // Reads only happen in RUN; loading is finished by then, so no read/write collision.
  assign ram_re     = fetch_en && (state_q == RUN) && !addr_fault;

`ifdef IMEM_PARITY_EN
  assign ram_wdata = {^wr_word, wr_word};
  assign ram_word  = ram_rdata[DATA_WIDTH-1:0];
  assign par_err   = use_ram_q & (^ram_rdata);
`else
  assign ram_wdata = wr_word;
  assign ram_word  = ram_rdata;
  assign par_err   = 1'b0;
`endif

  imem_ram #(
    .ADDR_BITS (ADDR_BITS),
    .WIDTH     (RAM_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ptr_q),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (fetch_idx),
    .rdata_o (ram_rdata)
  );

  // Next value of the fetch result flags; Stall freezes everything.
  always_comb begin
    valid_d   = valid_q;
    fault_d   = fault_q;
    use_ram_d = use_ram_q;
    if (!Stall) begin
      if (!FetchReq) begin
        valid_d = 1'b0;
      end else if (state_q != RUN) begin
        valid_d   = 1'b0;
        fault_d   = 1'b0;
        use_ram_d = 1'b0;
      end else if (addr_fault) begin
        valid_d   = 1'b1;
        fault_d   = 1'b1;
        use_ram_d = 1'b0;
      end else begin
        valid_d   = 1'b1;
        fault_d   = 1'b0;
        use_ram_d = 1'b1;
      end
    end
  end

  // Fetch result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
      use_ram_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      fault_q   <= fault_d;
      use_ram_q <= use_ram_d;
    end
  end

  assign Instruction = (use_ram_q && !par_err) ? ram_word : NOP_WORD;
  assign InstrValid  = valid_q;
  assign AddrFault   = fault_q | par_err;

endmodule

// File: tb/tb_instruction_memory_loader.sv
module tb_instruction_memory_loader;

  localparam int          ADDR_BITS = 8;
  localparam int          DEPTH     = 256;
  localparam logic [31:0] NOP       = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        FetchReq;
  logic [31:0] Address;
  logic        Stall;
  logic [31:0] Instruction;
  logic        InstrValid;
  logic        AddrFault;
  logic        LoadValid;
  logic [31:0] LoadData;
  logic        LoadLast;
  logic        LoadReady;
  logic        LoadDone;
  logic        Reload;

  int checks   = 0;
  int failures = 0;

  // Reference model: memory contents as seen by a fetch, plus expected outputs.
  logic [31:0] mem_m [DEPTH];
  bit          run_m;
  logic [31:0] exp_instr;
  logic        exp_valid;
  logic        exp_fault;
  logic [31:0] prog_q [$];
  int          prog_len;

  instruction_memory_loader #(
    .ADDR_BITS  (ADDR_BITS),
    .DATA_WIDTH (32),
    .NOP_WORD   (NOP)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .FetchReq    (FetchReq),
    .Address     (Address),
    .Stall       (Stall),
    .Instruction (Instruction),
    .InstrValid  (InstrValid),
    .AddrFault   (AddrFault),
    .LoadValid   (LoadValid),
    .LoadData    (LoadData),
    .LoadLast    (LoadLast),
    .LoadReady   (LoadReady),
    .LoadDone    (LoadDone),
    .Reload      (Reload)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = NOP;
    run_m = 1'b0;
  endfunction

  function automatic void model_reset();
    exp_instr = NOP;
    exp_valid = 1'b0;
    exp_fault = 1'b0;
    model_clear();
  endfunction

  // Expected effect of one clock edge on the fetch outputs.
  function automatic void model_fetch(input bit freq, input logic [31:0] addr, input bit stall);
    if (!stall) begin
      if (!freq) begin
        exp_valid = 1'b0;
      end else if (!run_m) begin
        exp_valid = 1'b0;
        exp_instr = NOP;
        exp_fault = 1'b0;
      end else if ((addr % 4) != 0 || addr >= DEPTH * 4) begin
        exp_valid = 1'b1;
        exp_instr = NOP;
        exp_fault = 1'b1;
      end else begin
        exp_valid = 1'b1;
        exp_instr = mem_m[addr / 4];
        exp_fault = 1'b0;
      end
    end
  endfunction

  task automatic step(input bit freq, input logic [31:0] addr, input bit stall);
    FetchReq = freq;
    Address  = addr;
    Stall    = stall;
    model_fetch(freq, addr, stall);
    tick();
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (LoadReady !== 1'b1 && n < 1000) begin
      model_fetch(FetchReq, Address, Stall);
      tick();
      n++;
    end
  endtask

  task automatic load_prog(input bit use_last);
    int gap;
    for (int i = 0; i < prog_q.size(); i++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        LoadValid = 1'b0;
        Reload    = 1'($urandom_range(0, 1));
        model_fetch(FetchReq, Address, Stall);
        tick();
      end
      Reload    = 1'($urandom_range(0, 1));
      LoadValid = 1'b1;
      LoadData  = prog_q[i];
      LoadLast  = use_last && (i == prog_q.size() - 1);
      checks++;
      if (LoadReady !== 1'b1) begin
        failures++;
        $display("FAIL load_ready word %0d: got %b want 1", i, LoadReady);
      end
      model_fetch(FetchReq, Address, Stall);
      tick();
      mem_m[i] = prog_q[i];
    end
    LoadValid = 1'b0;
    LoadLast  = 1'b0;
    Reload    = 1'b0;
  endtask

  task automatic reload_to_clear();
    int n;
    FetchReq = 1'b0;
    Reload   = 1'b1;
    model_fetch(1'b0, Address, Stall);
    tick();
    Reload = 1'b0;
    model_clear();
    wait_clear(n);
    checks++;
    if (n != DEPTH) begin
      failures++;
      $display("FAIL reload_clear_len: got %0d cycles want %0d", n, DEPTH);
    end
  endtask

  task automatic random_fetches(input int cycles);
    logic [31:0] addr;
    int kind, idx;
    bit freq, stall;
    for (int c = 0; c < cycles; c++) begin
      kind = $urandom_range(0, 9);
      idx  = $urandom_range(0, DEPTH - 1);
      if (kind == 0) addr = (32'(idx) << 2) + 32'($urandom_range(1, 3));
      else if (kind == 1) addr = (32'(idx) << 2) | (32'd1 << $urandom_range(10, 31));
      else if (kind < 6) addr = 32'($urandom_range(0, prog_len - 1)) << 2;
      else addr = 32'(idx) << 2;
      freq  = ($urandom_range(0, 4) != 0);
      stall = ($urandom_range(0, 3) == 0);
      step(freq, addr, stall);
      checks += 3;
      if (Instruction !== exp_instr) begin
        failures++;
        $display("FAIL rand_instr cyc %0d addr %h: got %h want %h", c, addr, Instruction, exp_instr);
      end
      if (InstrValid !== exp_valid) begin
        failures++;
        $display("FAIL rand_valid cyc %0d addr %h: got %b want %b", c, addr, InstrValid, exp_valid);
      end
      if (AddrFault !== exp_fault) begin
        failures++;
        $display("FAIL rand_fault cyc %0d addr %h: got %b want %b", c, addr, AddrFault, exp_fault);
      end
    end
    FetchReq = 1'b0;
    Stall    = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    #2;
    checks += 5;
    if (Instruction !== NOP) begin failures++; $display("FAIL reset_instr: got %h want %h", Instruction, NOP); end
    if (InstrValid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", InstrValid); end
    if (AddrFault !== 1'b0) begin failures++; $display("FAIL reset_fault: got %b want 0", AddrFault); end
    if (LoadReady !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", LoadReady); end
    if (LoadDone !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", LoadDone); end
    #10;
    reset    = 1'b1;
    FetchReq = 1'b1;
    Address  = 32'h0;
    wait_clear(n);
    FetchReq = 1'b0;
    checks += 4;
    if (n != DEPTH) begin failures++; $display("FAIL clear_len: got %0d cycles want %0d", n, DEPTH); end
    if (InstrValid !== 1'b0) begin failures++; $display("FAIL clear_fetch_valid: got %b want 0", InstrValid); end
    if (Instruction !== NOP) begin failures++; $display("FAIL clear_fetch_instr: got %h want %h", Instruction, NOP); end
    if (LoadDone !== 1'b0) begin failures++; $display("FAIL clear_done: got %b want 0", LoadDone); end
  endtask

  task automatic test_load_basic();
    logic [31:0] want [4];
    want[0] = 32'h20040003;
    want[1] = 32'h20010002;
    want[2] = 32'h1000ffff;
    want[3] = NOP;
    prog_q = '{32'h20040003, 32'h20010002, 32'h1000ffff};
    prog_len = 3;
    load_prog(1'b1);
    run_m = 1'b1;
    checks += 2;
    if (LoadDone !== 1'b1) begin failures++; $display("FAIL load_done: got %b want 1", LoadDone); end
    if (LoadReady !== 1'b0) begin failures++; $display("FAIL run_ready: got %b want 0", LoadReady); end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'(i * 4), 1'b0);
      checks += 2;
      if (Instruction !== want[i]) begin
        failures++;
        $display("FAIL fetch_word %0d: got %h want %h", i, Instruction, want[i]);
      end
      if (InstrValid !== 1'b1) begin
        failures++;
        $display("FAIL fetch_valid %0d: got %b want 1", i, InstrValid);
      end
    end
  endtask

  task automatic test_stall();
    step(1'b1, 32'h4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h8, 1'b1);
      checks += 2;
      if (Instruction !== 32'h20010002) begin
        failures++;
        $display("FAIL stall_hold %0d: got %h want 20010002", i, Instruction);
      end
      if (InstrValid !== 1'b1) begin
        failures++;
        $display("FAIL stall_valid %0d: got %b want 1", i, InstrValid);
      end
    end
    step(1'b1, 32'h8, 1'b0);
    checks++;
    if (Instruction !== 32'h1000ffff) begin failures++; $display("FAIL after_stall: got %h want 1000ffff", Instruction); end
    step(1'b0, 32'h0, 1'b0);
    checks += 2;
    if (InstrValid !== 1'b0) begin failures++; $display("FAIL idle_valid: got %b want 0", InstrValid); end
    if (Instruction !== 32'h1000ffff) begin failures++; $display("FAIL idle_hold: got %h want 1000ffff", Instruction); end
  endtask

  task automatic test_fault();
    logic [31:0] bad [2];
    bad[0] = 32'h6;
    bad[1] = 32'h400;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, bad[i], 1'b0);
      checks += 3;
      if (Instruction !== NOP) begin failures++; $display("FAIL fault_instr %h: got %h want %h", bad[i], Instruction, NOP); end
      if (AddrFault !== 1'b1) begin failures++; $display("FAIL fault_flag %h: got %b want 1", bad[i], AddrFault); end
      if (InstrValid !== 1'b1) begin failures++; $display("FAIL fault_valid %h: got %b want 1", bad[i], InstrValid); end
    end
    step(1'b1, 32'h0, 1'b0);
    checks += 2;
    if (AddrFault !== 1'b0) begin failures++; $display("FAIL fault_clear: got %b want 0", AddrFault); end
    if (Instruction !== 32'h20040003) begin failures++; $display("FAIL fault_recover: got %h want 20040003", Instruction); end
  endtask

  task automatic test_reload();
    int n;
    FetchReq = 1'b1;
    Address  = 32'h4;
    Stall    = 1'b0;
    Reload   = 1'b1;
    model_fetch(1'b1, 32'h4, 1'b0);
    tick();
    Reload   = 1'b0;
    FetchReq = 1'b0;
    model_clear();
    checks += 3;
    if (Instruction !== 32'h20010002) begin failures++; $display("FAIL reload_fetch_old: got %h want 20010002", Instruction); end
    if (InstrValid !== 1'b1) begin failures++; $display("FAIL reload_fetch_valid: got %b want 1", InstrValid); end
    if (LoadDone !== 1'b0) begin failures++; $display("FAIL reload_done_drop: got %b want 0", LoadDone); end
    wait_clear(n);
    checks++;
    if (n != DEPTH) begin failures++; $display("FAIL reload_clear_len: got %0d cycles want %0d", n, DEPTH); end
  endtask

  task automatic test_reset_midload();
    int n;
    logic [31:0] w;
    prog_q = '{$urandom, $urandom};
    load_prog(1'b0);
    checks += 2;
    if (LoadDone !== 1'b0) begin failures++; $display("FAIL midload_done: got %b want 0", LoadDone); end
    if (LoadReady !== 1'b1) begin failures++; $display("FAIL midload_ready: got %b want 1", LoadReady); end
    reset = 1'b0;
    #1;
    checks += 4;
    if (Instruction !== NOP) begin failures++; $display("FAIL midreset_instr: got %h want %h", Instruction, NOP); end
    if (InstrValid !== 1'b0) begin failures++; $display("FAIL midreset_valid: got %b want 0", InstrValid); end
    if (LoadReady !== 1'b0) begin failures++; $display("FAIL midreset_ready: got %b want 0", LoadReady); end
    if (LoadDone !== 1'b0) begin failures++; $display("FAIL midreset_done: got %b want 0", LoadDone); end
    #1;
    reset = 1'b1;
    model_reset();
    wait_clear(n);
    checks++;
    if (n != DEPTH) begin failures++; $display("FAIL midreset_clear_len: got %0d cycles want %0d", n, DEPTH); end
    w = $urandom | 32'h1;
    prog_q = '{w};
    prog_len = 1;
    load_prog(1'b1);
    run_m = 1'b1;
    step(1'b1, 32'h0, 1'b0);
    checks += 2;
    if (Instruction !== w) begin failures++; $display("FAIL newload_word0: got %h want %h", Instruction, w); end
    if (InstrValid !== 1'b1) begin failures++; $display("FAIL newload_valid: got %b want 1", InstrValid); end
    step(1'b1, 32'h4, 1'b0);
    checks++;
    if (Instruction !== NOP) begin failures++; $display("FAIL newload_word1_discarded: got %h want %h", Instruction, NOP); end
  endtask

  task automatic test_full_depth();
    reload_to_clear();
    prog_q.delete();
    for (int i = 0; i < DEPTH; i++) prog_q.push_back($urandom);
    prog_len = DEPTH;
    load_prog(1'b0);
    run_m = 1'b1;
    checks += 2;
    if (LoadDone !== 1'b1) begin failures++; $display("FAIL full_depth_done: got %b want 1", LoadDone); end
    if (LoadReady !== 1'b0) begin failures++; $display("FAIL full_depth_ready: got %b want 0", LoadReady); end
    random_fetches(300);
  endtask

  task automatic test_random_program();
    reload_to_clear();
    prog_q.delete();
    prog_len = $urandom_range(4, 40);
    for (int i = 0; i < prog_len; i++) prog_q.push_back($urandom);
    load_prog(1'b1);
    run_m = 1'b1;
    checks++;
    if (LoadDone !== 1'b1) begin failures++; $display("FAIL rand_prog_done: got %b want 1", LoadDone); end
    random_fetches(300);
  endtask

`ifdef IMEM_PARITY_EN
  task automatic test_parity();
    reload_to_clear();
    prog_q = '{32'h20040003, 32'h20010002, 32'h1000ffff};
    prog_len = 3;
    load_prog(1'b1);
    run_m = 1'b1;
    u_dut.u_ram.mem_q[1] = u_dut.u_ram.mem_q[1] ^ 33'd1;
    step(1'b1, 32'h4, 1'b0);
    checks += 2;
    if (Instruction !== NOP) begin failures++; $display("FAIL parity_instr: got %h want %h", Instruction, NOP); end
    if (AddrFault !== 1'b1) begin failures++; $display("FAIL parity_fault: got %b want 1", AddrFault); end
    step(1'b1, 32'h0, 1'b0);
    checks += 2;
    if (Instruction !== 32'h20040003) begin failures++; $display("FAIL parity_good_word: got %h want 20040003", Instruction); end
    if (AddrFault !== 1'b0) begin failures++; $display("FAIL parity_good_fault: got %b want 0", AddrFault); end
  endtask
`endif

  initial begin
    reset     = 1'b0;
    FetchReq  = 1'b0;
    Address   = 32'h0;
    Stall     = 1'b0;
    LoadValid = 1'b0;
    LoadData  = 32'h0;
    LoadLast  = 1'b0;
    Reload    = 1'b0;
    prog_len  = 1;
    model_reset();
    test_reset();
    test_load_basic();
    test_stall();
    test_fault();
    random_fetches(150);
    test_reload();
    test_reset_midload();
    test_full_depth();
    test_random_program();
`ifdef IMEM_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
